// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: datapath widths, major opcodes and the
// fetch packet handed from the front-end to decode.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_ring.sv
// In-order prefetch ring: slots are allocated at request time (holding the PC),
// filled when the response returns, and drained by decode from the head.
module fetch_ring
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alloc_en,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill_en,
    input  logic [ILEN-1:0] fill_data,
    input  logic            deq_en,
    output logic            head_valid,
    output fetch_pkt_t      head_pkt,
    output logic [PW-1:0]   occupancy,
    output logic [PW-1:0]   inflight
);

    localparam int AW = PW - 1;

    logic [PW-1:0]   alloc_ptr, fill_ptr, head_ptr;
    logic [AW-1:0]   alloc_idx, fill_idx, head_idx;
    logic [DEPTH-1:0] full;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign head_idx  = head_ptr[AW-1:0];

    // The three pointer regions never alias while the top respects the
    // occupancy bound, so the per-bit full updates below cannot collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            full      <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            full      <= '0;
        end else begin
            if (alloc_en) begin
                full[alloc_idx] <= 1'b0;
                alloc_ptr       <= alloc_ptr + PW'(1);
            end
            if (fill_en) begin
                full[fill_idx] <= 1'b1;
                fill_ptr       <= fill_ptr + PW'(1);
            end
            if (deq_en) begin
                full[head_idx] <= 1'b0;
                head_ptr       <= head_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en && !flush)
            pc_mem[alloc_idx] <= alloc_pc;
        if (fill_en && !flush)
            instr_mem[fill_idx] <= fill_data;
    end

    assign head_valid     = full[head_idx];
    assign head_pkt.pc    = pc_mem[head_idx];
    assign head_pkt.instr = instr_mem[head_idx];
    assign occupancy      = alloc_ptr - head_ptr;
    assign inflight       = alloc_ptr - fill_ptr;

endmodule

// File: rtl/rv_fetch_unit.sv
// RV32I instruction fetch front-end: issues word requests, discards stale
// responses after a redirect and feeds decode from the prefetch ring.
// Optional FETCH_MISALIGN_TRAP_EN adds a sticky fault on misaligned redirects.
module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            fetch_fault,
`endif
    input  logic            if_ready
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] redirect_target;
    logic [PW-1:0]   discard_cnt;
    logic [PW-1:0]   occupancy;
    logic [PW-1:0]   inflight;
    logic [PW:0]     slots_used;
    logic            req_fire;
    logic            rsp_drop;
    logic            fill_en;
    logic            deq_en;
    logic            fault_block;
    fetch_pkt_t      head_pkt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault_q <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            fault_q <= 1'b1;
    end

    assign fetch_fault     = fault_q;
    assign fault_block     = fault_q;
    assign redirect_target = redirect_pc;
`else
    assign fault_block     = 1'b0;
    assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

    // Stale responses still owed by memory occupy ring capacity until dropped.
    assign slots_used     = {1'b0, occupancy} + {1'b0, discard_cnt};
    assign imem_req_valid = !rst && !redirect_valid && !fault_block
                            && (slots_used < (PW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && (discard_cnt != '0);
    assign fill_en  = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign deq_en   = if_valid && if_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_pc <= RESET_PC;
        else if (redirect_valid)
            fetch_pc <= redirect_target;
        else if (req_fire)
            fetch_pc <= fetch_pc + 32'd4;
    end

    // A response landing in the redirect cycle is already part of the old stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            discard_cnt <= '0;
        else if (redirect_valid)
            discard_cnt <= discard_cnt + inflight - {{(PW-1){1'b0}}, imem_rsp_valid};
        else if (rsp_drop)
            discard_cnt <= discard_cnt - PW'(1);
    end

    fetch_ring #(
        .DEPTH(DEPTH)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .alloc_en   (req_fire),
        .alloc_pc   (fetch_pc),
        .fill_en    (fill_en),
        .fill_data  (imem_rsp_data),
        .deq_en     (deq_en),
        .head_valid (if_valid),
        .head_pkt   (head_pkt),
        .occupancy  (occupancy),
        .inflight   (inflight)
    );

    assign if_instr = head_pkt.instr;
    assign if_pc    = head_pkt.pc;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: a latency-configurable memory model and a
// scoreboard of expected {pc, instr} deliveries checked at every decode handshake.
module tb_rv_fetch_unit;
    import rv_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    mem_req_t    memq[$];
    fetch_pkt_t  exp_out[$];
    int          errors = 0;
    int          checks = 0;
    int          deliveries = 0;
    int          accepts = 0;
    int          edge_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] model_pc = 32'h0;

    rv_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault    (fetch_fault),
`endif
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic ifr,
                                 input logic mrdy, input int cycles);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = ifr;
        imem_req_ready = mrdy;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic resetDut(input int lat);
        rst     = 1'b1;
        mem_lat = lat;
        @(negedge clk);
        rst        = 1'b0;
        accepts    = 0;
        deliveries = 0;
    endtask

    task automatic waitIfValid(input string tag);
        int n = 0;
        while (!if_valid && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 32'(n < 40), 32'd1);
    endtask

    // Memory response driver: in-order, one response per cycle once due.
    always @(negedge clk) begin
        if (memq.size() > 0 && memq[0].due <= edge_cnt + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // Sampler just before each rising edge: handshakes seen here complete at that edge.
    always @(negedge clk) begin
        fetch_pkt_t exp_pkt;
        #3;
        if (rst) begin
            memq.delete();
            exp_out.delete();
            model_pc = 32'h0;
        end else begin
            if (if_valid && if_ready) begin
                deliveries++;
                if (exp_out.size() == 0) begin
                    checkOutput("deliver_sb_empty", 32'(exp_out.size()), 32'd1);
                end else begin
                    exp_pkt = exp_out.pop_front();
                    checkOutput("deliver_pc", if_pc, exp_pkt.pc);
                    checkOutput("deliver_instr", if_instr, exp_pkt.instr);
                end
            end
            if (redirect_valid) begin
                checkOutput("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
                exp_out.delete();
                model_pc = redirect_pc & ~32'h3;
            end
            if (imem_req_valid && imem_req_ready) begin
                checkOutput("req_addr", imem_req_addr, model_pc);
                memq.push_back('{addr: imem_req_addr, due: edge_cnt + 1 + mem_lat});
                exp_out.push_back('{pc: model_pc, instr: memWord(model_pc)});
                model_pc = model_pc + 32'd4;
                accepts++;
            end
            if (imem_rsp_valid && memq.size() > 0)
                memq.delete(0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;
        imem_req_ready = 1'b1;
        mem_lat        = 1;

        // Reset values, then streaming with a 1-cycle memory
        @(negedge clk);
        #1;
        checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("reset_if_valid", 32'(if_valid), 32'd0);
        checkOutput("reset_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        accepts    = 0;
        deliveries = 0;
        #1;
        checkOutput("post_reset_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("post_reset_req_addr", imem_req_addr, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 10);
        #1;
        checkOutput("throughput_10cyc", 32'(deliveries), 32'd8);

        // Back-pressure: ring fills to DEPTH and requests stop
        rst      = 1'b1;
        if_ready = 1'b0;
        #1;
        checkOutput("midrun_reset_if_valid", 32'(if_valid), 32'd0);
        checkOutput("midrun_reset_req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        accepts    = 0;
        deliveries = 0;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("bp_accepts", 32'(accepts), 32'd4);
        checkOutput("bp_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("bp_if_valid", 32'(if_valid), 32'd1);
        checkOutput("bp_head_pc", if_pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 8);

        // Memory stall: address holds at 0x8
        resetDut(1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0);
        checkOutput("stall_accepts", 32'(accepts), 32'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd1);
            checkOutput("stall_req_addr", imem_req_addr, 32'h8);
            @(negedge clk);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 8);

        // Redirect with responses in flight (3-cycle memory)
        resetDut(3);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 8);
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 0);
        #1;
        checkOutput("redir_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("redir_req_addr", imem_req_addr, 32'h40);
        checkOutput("redir_if_valid", 32'(if_valid), 32'd0);
        waitIfValid("redir_wait_if_valid");
        checkOutput("redir_first_pc", if_pc, 32'h40);
        checkOutput("redir_first_instr", if_instr, memWord(32'h40));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 10);

        // Redirect coinciding with a response and a decode handshake
        resetDut(1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 6);
        #1;
        checkOutput("coinc_if_valid", 32'(if_valid), 32'd1);
        checkOutput("coinc_rsp_valid", 32'(imem_rsp_valid), 32'd1);
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 0);
        #1;
        checkOutput("coinc_req_addr", imem_req_addr, 32'h80);
        checkOutput("coinc_if_valid_after", 32'(if_valid), 32'd0);
        waitIfValid("coinc_wait_if_valid");
        checkOutput("coinc_first_pc", if_pc, 32'h80);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 8);

        // Back-to-back redirects: last one wins
        resetDut(3);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 6);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 1);
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 0);
        #1;
        checkOutput("b2b_req_addr", imem_req_addr, 32'h200);
        waitIfValid("b2b_wait_if_valid");
        checkOutput("b2b_first_pc", if_pc, 32'h200);
        checkOutput("b2b_first_instr", if_instr, memWord(32'h200));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 12);

        // Misaligned redirect target
        applyStimulus(1'b1, 32'h42, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 0);
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("misalign_fault", 32'(fetch_fault), 32'd1);
        checkOutput("misalign_req_valid", 32'(imem_req_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 6);
        #1;
        checkOutput("misalign_still_blocked", 32'(imem_req_valid), 32'd0);
`else
        checkOutput("misalign_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("misalign_req_addr", imem_req_addr, 32'h40);
        waitIfValid("misalign_wait_if_valid");
        checkOutput("misalign_first_pc", if_pc, 32'h40);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_fetch_unit.md
# rv_fetch_unit

Instruction fetch front-end for the pipelined RV32I core. It sits directly upstream of the fetch/decode registers and replaces the file-preloaded program memory path. It issues word requests to an external instruction memory over a valid/ready handshake and buffers returned instructions, tagged with their PC, in an in-order prefetch ring. Decode drains the ring through a valid/ready handshake, and an execute-stage redirect flushes it.

## Interface
- `DEPTH`, 4 — ring entries; power of two, ≥2; also the maximum number of requests in flight.
- `RESET_PC`, 32'h0000_0000 — first fetch address after reset.
- `clk` in 1 — rising-edge clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `imem_req_valid` out 1 — request valid.
- `imem_req_addr` out 32 — byte address, word-aligned.
- `imem_req_ready` in 1 — memory accepts the request.
- `imem_rsp_valid` in 1 — response valid; responses return in order, ≥1 cycle after acceptance, and are never back-pressured.
- `imem_rsp_data` in 32 — instruction word.
- `redirect_valid` in 1 — taken branch, JAL or JALR resolved.
- `redirect_pc` in 32 — new fetch address.
- `if_valid` out 1 — head entry holds an instruction.
- `if_instr` out 32 — head instruction.
- `if_pc` out 32 — PC of the head instruction.
- `if_ready` in 1 — decode consumes the head.
- `fetch_fault` out 1 — present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- **Ring pointers:** the ring has three `$clog2(DEPTH)+1`-bit pointers, `alloc`, `fill` and `head`, plus a per-entry `{pc, instr, full}`. The extra MSB distinguishes full from empty. `occupancy = alloc - head`; `inflight = alloc - fill`.
- **`fetch_pc` register:**
  - Reset value is `RESET_PC`.
  - Advances by +4 on each accepted request (`imem_req_valid && imem_req_ready`); the adder wraps modulo 2^32.
- **Request issue:**
  - `imem_req_valid = !redirect_valid && (occupancy + discard_cnt < DEPTH)`.
  - `imem_req_addr = fetch_pc`.
  - On acceptance, write `pc` into entry `alloc`, clear its `full` bit, and increment `alloc`.
- **Response handling:**
  - If `discard_cnt > 0`, drop the response and decrement `discard_cnt`.
  - Otherwise write `imem_rsp_data` into entry `fill`, set `full`, and increment `fill`.
- **Drain:** `if_valid = full[head]`. When `if_valid && if_ready`, clear `full[head]` and increment `head`.
- **Redirect (one cycle, priority over everything):**
  - `fetch_pc <= redirect_pc`.
  - `alloc`, `fill` and `head` reset to 0.
  - All `full` bits clear.
  - `discard_cnt <= discard_cnt + inflight - (response this cycle ? 1 : 0)`. A response arriving in the redirect cycle belongs to the old stream and is dropped.
  - A decode handshake completing in the redirect cycle counts as delivered.
- **Bound:** `discard_cnt + occupancy ≤ DEPTH` always holds, so `discard_cnt` is `$clog2(DEPTH)+1` bits and never overflows.
- **Stall behaviour:** a full ring with `if_ready` low holds all state and keeps `imem_req_valid` low.

## Timing
- **Reset values:** `imem_req_valid` 0 while `rst` is high, `if_valid` 0, `fetch_pc` = `RESET_PC`, all pointers 0, `discard_cnt` 0, `fetch_fault` 0.
- **After reset:** `imem_req_valid` rises in the first cycle after `rst` deasserts.
- **Response latency:** a response sampled at edge N gives `if_valid` = 1 after edge N. Minimum request-to-decode latency is 2 cycles with a 1-cycle memory.
- **Throughput:** 1 instruction/cycle sustained when memory latency ≤ DEPTH−1.
- **Redirect latency:** a redirect sampled at edge k gives `imem_req_addr` = `redirect_pc` with valid high in cycle k+1, and `if_valid` = 0 in cycle k+1.
- **Back-to-back redirects:** each redirect accumulates into `discard_cnt`, and the last one wins.
- **Reset mid-operation:** reset asserted at any time clears state immediately; late responses after reset are the memory's responsibility (memory is reset by the same `rst`).

## Configuration
- **`FETCH_MISALIGN_TRAP_EN` defined:**
  - A redirect with `redirect_pc[1:0] != 0` sets the sticky `fetch_fault` and raises no new requests until reset.
  - `if_valid` still drains instructions already filled.
- **Undefined:** `redirect_pc[1:0]` is forced to 00, and `fetch_fault` is absent.

## Structure
- **Shared package `rv_pkg`:**
  - `XLEN` = 32.
  - `ILEN` = 32.
  - Opcode constants `OP_R`, `OP_I`, `OP_S`, `OP_B`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_LOAD`.
  - `typedef struct {pc, instr}` as `fetch_pkt_t`.
- **Sub-module:** `fetch_ring`, holding the storage, the pointers and the full/empty logic. The top holds `fetch_pc`, `discard_cnt`, the handshakes and the fault logic.

## Test plan
- **Reset and 1-cycle memory, `if_ready` = 1:** requests go to 0x0, 0x4, 0x8, … consecutively. `if_pc`/`if_instr` follow in order from cycle 2, at 1 per cycle.
- **Back-pressure:** `if_ready` = 0, DEPTH = 4, memory always ready → exactly 4 requests (0x0–0xC) are accepted, then `imem_req_valid` stays 0. Raising `if_ready` delivers 0x0 first.
- **Redirect with 3 in flight:** 3-cycle memory latency, `redirect_pc` = 0x40 → the next 3 responses are dropped, and the first `if_pc` delivered is 0x40 with its memory word.
- **Redirect coinciding with a response and with a decode handshake:** the handshaken instruction is delivered once, the coincident response is dropped, and `discard_cnt` ends at 0 after the remaining in-flight responses.
- **Memory stall:** `imem_req_ready` low for 5 cycles → `imem_req_addr` holds 0x8 stable, and no PC is skipped.
- **With `FETCH_MISALIGN_TRAP_EN`:** redirect to 0x42 → `fetch_fault` = 1 next cycle and no further requests. Without the macro, the same redirect fetches 0x40.
